// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads opcode/operand bytes at the program counter and hands
// complete instructions to the decoder. Define FETCH_PREFETCH_EN for a one-entry prefetch buffer.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] pc_value,
  output logic                  pc_step,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_load_val,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  jump_req,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  halt,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_opcode,
  output logic [DATA_WIDTH-1:0] instr_operand,
  output logic                  instr_has_arg,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  halted
);

  typedef enum logic [1:0] {StIdle, StOp, StArg, StHold} state_t;

  state_t state_q;
  logic   fetch_req;
  logic   byte_ok;
  logic   accept;

`ifdef FETCH_PREFETCH_EN
  logic                  buf_valid_q;
  logic [DATA_WIDTH-1:0] buf_op_q;
  logic [ADDR_WIDTH-1:0] buf_pc_q;
  logic                  next_hit;
  logic [DATA_WIDTH-1:0] next_op;
  logic [ADDR_WIDTH-1:0] next_pc;

  // In hold the bus keeps fetching the following opcode until the buffer is full.
  assign fetch_req = (state_q == StOp) || (state_q == StArg) ||
                     ((state_q == StHold) && !buf_valid_q);
  // A byte landing in the accept cycle itself is used just like a buffered one.
  assign next_hit  = buf_valid_q || byte_ok;
  assign next_op   = buf_valid_q ? buf_op_q : mem_rdata;
  assign next_pc   = buf_valid_q ? buf_pc_q : pc_value;
`else
  assign fetch_req = (state_q == StOp) || (state_q == StArg);
`endif

  // Jump has priority: a byte returned alongside a jump is dropped and not counted.
  assign pc_load     = (state_q != StIdle) && jump_req;
  assign pc_load_val = jump_addr;
  assign byte_ok     = fetch_req && mem_ready && !jump_req;
  assign pc_step     = byte_ok;
  assign mem_req     = fetch_req;
  assign mem_addr    = pc_value;
  assign accept      = instr_valid && instr_ready;
  assign halted      = (state_q == StIdle) && halt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      instr_valid   <= 1'b0;
      instr_opcode  <= '0;
      instr_operand <= '0;
      instr_has_arg <= 1'b0;
      instr_pc      <= '0;
`ifdef FETCH_PREFETCH_EN
      buf_valid_q   <= 1'b0;
      buf_op_q      <= '0;
      buf_pc_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!halt) state_q <= StOp;
        end
        StOp: begin
          if (byte_ok) begin
            instr_opcode  <= mem_rdata;
            instr_pc      <= pc_value;
            instr_has_arg <= mem_rdata[DATA_WIDTH-1];
            instr_operand <= '0;
            if (mem_rdata[DATA_WIDTH-1]) begin
              state_q <= StArg;
            end else begin
              state_q     <= StHold;
              instr_valid <= 1'b1;
            end
          end
        end
        StArg: begin
          if (jump_req) begin
            state_q <= StOp;
          end else if (mem_ready) begin
            instr_operand <= mem_rdata;
            instr_valid   <= 1'b1;
            state_q       <= StHold;
          end
        end
        StHold: begin
          if (jump_req) begin
            instr_valid <= 1'b0;
            state_q     <= StOp;
`ifdef FETCH_PREFETCH_EN
            buf_valid_q <= 1'b0;
`endif
          end else if (accept) begin
            instr_valid <= 1'b0;
            if (halt) begin
              state_q       <= StIdle;
              instr_opcode  <= '0;
              instr_operand <= '0;
              instr_has_arg <= 1'b0;
              instr_pc      <= '0;
`ifdef FETCH_PREFETCH_EN
              buf_valid_q   <= 1'b0;
`endif
            end else begin
`ifdef FETCH_PREFETCH_EN
              buf_valid_q <= 1'b0;
              if (next_hit) begin
                instr_opcode  <= next_op;
                instr_pc      <= next_pc;
                instr_has_arg <= next_op[DATA_WIDTH-1];
                instr_operand <= '0;
                if (next_op[DATA_WIDTH-1]) begin
                  state_q <= StArg;
                end else begin
                  state_q     <= StHold;
                  instr_valid <= 1'b1;
                end
              end else begin
                state_q <= StOp;
              end
`else
              state_q <= StOp;
`endif
            end
          end
`ifdef FETCH_PREFETCH_EN
          else if (byte_ok) begin
            buf_valid_q <= 1'b1;
            buf_op_q    <= mem_rdata;
            buf_pc_q    <= pc_value;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
